// File: rtl/scr1_dm_regs.sv
`default_nettype none
// ============================================================================
// Module   : scr1_dm_regs
// Purpose  : Debug-module DMI register file with abstract-command sequencer.
//            Optional macro SCR1_DMI_PROGBUF_EN adds progbuf0/progbuf1.
// Revision : 1.0
// ============================================================================
module scr1_dm_regs #(
  parameter int SCR1_DBG_DMI_ADDR_WIDTH = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               dmi_req,
  input  logic                               dmi_wr,
  input  logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0] dmi_addr,
  input  logic [31:0]                        dmi_wdata,
  output logic                               dmi_resp,
  output logic [31:0]                        dmi_rdata,
  input  logic                               hart_halted,
  output logic                               hart_halt_req,
  output logic                               hart_resume_req,
  input  logic                               hart_resume_ack,
  output logic                               dm_active,
  output logic                               ndm_reset,
  output logic                               cmd_req,
  output logic                               cmd_write,
  output logic [15:0]                        cmd_regno,
  output logic [31:0]                        cmd_wdata,
  input  logic                               cmd_ack,
  input  logic [31:0]                        cmd_rdata,
  input  logic                               cmd_err
);

  localparam logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0] c_ADDR_DATA0      = 'h04;
  localparam logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0] c_ADDR_DMCONTROL  = 'h10;
  localparam logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0] c_ADDR_DMSTATUS   = 'h11;
  localparam logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0] c_ADDR_HARTINFO   = 'h12;
  localparam logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0] c_ADDR_ABSTRACTCS = 'h16;
  localparam logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0] c_ADDR_COMMAND    = 'h17;
`ifdef SCR1_DMI_PROGBUF_EN
  localparam logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0] c_ADDR_PROGBUF0   = 'h20;
  localparam logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0] c_ADDR_PROGBUF1   = 'h21;
  localparam logic [4:0]                         c_PROGBUFSIZE     = 5'd2;
`else
  localparam logic [4:0]                         c_PROGBUFSIZE     = 5'd0;
`endif

  localparam logic [2:0] c_ERR_NONE    = 3'd0;
  localparam logic [2:0] c_ERR_BUSY    = 3'd1;
  localparam logic [2:0] c_ERR_UNSUPP  = 3'd2;
  localparam logic [2:0] c_ERR_EXCEPT  = 3'd3;
  localparam logic [2:0] c_ERR_HALTRES = 3'd4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_data0;
  logic        r_haltreq;
  logic        r_ndmreset;
  logic        r_dmactive;
  logic        r_resume_req;
  logic        r_resumeack;
  logic [2:0]  r_cmderr;
  logic        r_cmd_write;
  logic [15:0] r_cmd_regno;
  logic [31:0] r_cmd_wdata;

  logic        w_wr;
  logic        w_wr_data0;
  logic        w_wr_dmctrl;
  logic        w_wr_abscs;
  logic        w_wr_cmd;
  logic        w_wr_pb;
  logic        w_busy;
  logic        w_done;
  logic        w_hold;
  logic        w_abs_wr_busy;
  logic        w_cmd_ok;
  logic        w_cmd_illegal;
  logic        w_cmd_nohalt;
  logic        w_cmd_start;
  logic [31:0] w_rdata;

  assign w_wr        = dmi_req & dmi_wr;
  assign w_wr_data0  = w_wr & (dmi_addr == c_ADDR_DATA0);
  assign w_wr_dmctrl = w_wr & (dmi_addr == c_ADDR_DMCONTROL);
  assign w_wr_abscs  = w_wr & (dmi_addr == c_ADDR_ABSTRACTCS);
  assign w_wr_cmd    = w_wr & (dmi_addr == c_ADDR_COMMAND);

  assign w_busy = (r_state == ST_EXEC);
  assign w_done = w_busy & cmd_ack;

  // Inactive DM (or a write clearing dmactive) pins all debug state to reset values.
  assign w_hold = ~r_dmactive | (w_wr_dmctrl & ~dmi_wdata[0]);

  assign w_abs_wr_busy = w_busy & (w_wr_data0 | w_wr_cmd | w_wr_abscs | w_wr_pb);

  assign w_cmd_ok      = r_dmactive & w_wr_cmd & ~w_busy & (r_cmderr == c_ERR_NONE);
  assign w_cmd_illegal = w_cmd_ok & ((dmi_wdata[31:24] != 8'd0) | (dmi_wdata[22:20] != 3'd2));
  assign w_cmd_nohalt  = w_cmd_ok & ~w_cmd_illegal & dmi_wdata[17] & ~hart_halted;
  assign w_cmd_start   = w_cmd_ok & ~w_cmd_illegal & dmi_wdata[17] & hart_halted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_cmd_start) w_state_next = ST_EXEC;
      ST_EXEC: if (cmd_ack)     w_state_next = ST_IDLE;
      default:                  w_state_next = ST_IDLE;
    endcase
    if (w_hold) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data0      <= '0;
      r_haltreq    <= 1'b0;
      r_ndmreset   <= 1'b0;
      r_dmactive   <= 1'b0;
      r_resume_req <= 1'b0;
      r_resumeack  <= 1'b0;
      r_cmderr     <= c_ERR_NONE;
      r_cmd_write  <= 1'b0;
      r_cmd_regno  <= '0;
      r_cmd_wdata  <= '0;
    end else if (w_hold) begin
      r_data0      <= '0;
      r_haltreq    <= 1'b0;
      r_ndmreset   <= 1'b0;
      r_dmactive   <= w_wr_dmctrl & dmi_wdata[0];
      r_resume_req <= 1'b0;
      r_resumeack  <= 1'b0;
      r_cmderr     <= c_ERR_NONE;
      r_cmd_write  <= 1'b0;
      r_cmd_regno  <= '0;
      r_cmd_wdata  <= '0;
    end else begin
      if (w_wr_dmctrl) begin
        r_dmactive <= dmi_wdata[0];
        r_ndmreset <= dmi_wdata[1];
        r_haltreq  <= dmi_wdata[31];
      end

      if (w_wr_dmctrl && dmi_wdata[30] && !dmi_wdata[31]) begin
        r_resume_req <= 1'b1;
        r_resumeack  <= 1'b0;
      end else if (r_resume_req && hart_resume_ack) begin
        r_resume_req <= 1'b0;
        r_resumeack  <= 1'b1;
      end

      // A completing read owns data0 even if the debugger writes it in the same cycle.
      if (w_done && !cmd_err && !r_cmd_write) begin
        r_data0 <= cmd_rdata;
      end else if (w_wr_data0 && !w_busy) begin
        r_data0 <= dmi_wdata;
      end

      if (w_done && cmd_err) begin
        r_cmderr <= c_ERR_EXCEPT;
      end else if (w_abs_wr_busy) begin
        if (r_cmderr == c_ERR_NONE) r_cmderr <= c_ERR_BUSY;
      end else if (w_wr_abscs) begin
        r_cmderr <= r_cmderr & ~dmi_wdata[10:8];
      end else if (w_cmd_illegal) begin
        r_cmderr <= c_ERR_UNSUPP;
      end else if (w_cmd_nohalt) begin
        r_cmderr <= c_ERR_HALTRES;
      end

      if (w_cmd_start) begin
        r_cmd_write <= dmi_wdata[16];
        r_cmd_regno <= dmi_wdata[15:0];
        r_cmd_wdata <= r_data0;
      end
    end
  end

`ifdef SCR1_DMI_PROGBUF_EN
  logic [31:0] r_progbuf0;
  logic [31:0] r_progbuf1;
  logic        w_wr_pb0;
  logic        w_wr_pb1;

  assign w_wr_pb0 = w_wr & (dmi_addr == c_ADDR_PROGBUF0);
  assign w_wr_pb1 = w_wr & (dmi_addr == c_ADDR_PROGBUF1);
  assign w_wr_pb  = w_wr_pb0 | w_wr_pb1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_progbuf0 <= '0;
      r_progbuf1 <= '0;
    end else if (w_hold) begin
      r_progbuf0 <= '0;
      r_progbuf1 <= '0;
    end else if (!w_busy) begin
      if (w_wr_pb0) r_progbuf0 <= dmi_wdata;
      if (w_wr_pb1) r_progbuf1 <= dmi_wdata;
    end
  end
`else
  assign w_wr_pb = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    case (dmi_addr)
      c_ADDR_DATA0:      w_rdata = r_data0;
      c_ADDR_DMCONTROL:  w_rdata = {r_haltreq, 1'b0, 28'd0, r_ndmreset, r_dmactive};
      c_ADDR_DMSTATUS:   w_rdata = {14'd0, r_resumeack, r_resumeack, 4'd0,
                                    ~hart_halted, ~hart_halted, hart_halted, hart_halted,
                                    1'b1, 3'd0, 4'd2};
      c_ADDR_HARTINFO:   w_rdata = '0;
      c_ADDR_ABSTRACTCS: w_rdata = {3'd0, c_PROGBUFSIZE, 11'd0, w_busy, 1'b0,
                                    r_cmderr, 4'd0, 4'd1};
`ifdef SCR1_DMI_PROGBUF_EN
      c_ADDR_PROGBUF0:   w_rdata = r_progbuf0;
      c_ADDR_PROGBUF1:   w_rdata = r_progbuf1;
`endif
      default:           w_rdata = '0;
    endcase
  end

  assign dmi_resp        = dmi_req;
  assign dmi_rdata       = rst ? 32'd0 : w_rdata;
  assign hart_halt_req   = r_haltreq;
  assign hart_resume_req = r_resume_req;
  assign dm_active       = r_dmactive;
  assign ndm_reset       = r_ndmreset;
  assign cmd_req         = w_busy;
  assign cmd_write       = r_cmd_write;
  assign cmd_regno       = r_cmd_regno;
  assign cmd_wdata       = r_cmd_wdata;

endmodule
`default_nettype wire

// File: tb/tb_scr1_dm_regs.sv
`default_nettype none
// Directed bench for scr1_dm_regs: expected values queued as stimulus is
// applied, then popped and compared when the DUT output is sampled.
module tb_scr1_dm_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dmi_req = 1'b0;
  logic        dmi_wr = 1'b0;
  logic [5:0]  dmi_addr = '0;
  logic [31:0] dmi_wdata = '0;
  logic        dmi_resp;
  logic [31:0] dmi_rdata;
  logic        hart_halted = 1'b0;
  logic        hart_halt_req;
  logic        hart_resume_req;
  logic        hart_resume_ack = 1'b0;
  logic        dm_active;
  logic        ndm_reset;
  logic        cmd_req;
  logic        cmd_write;
  logic [15:0] cmd_regno;
  logic [31:0] cmd_wdata;
  logic        cmd_ack = 1'b0;
  logic [31:0] cmd_rdata = '0;
  logic        cmd_err = 1'b0;

  int errors = 0;
  int checks = 0;

`ifdef SCR1_DMI_PROGBUF_EN
  localparam logic [31:0] PBSZ = 32'h0200_0000;
`else
  localparam logic [31:0] PBSZ = 32'h0000_0000;
`endif

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  scr1_dm_regs dut (
    .clk(clk), .rst(rst),
    .dmi_req(dmi_req), .dmi_wr(dmi_wr), .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata),
    .dmi_resp(dmi_resp), .dmi_rdata(dmi_rdata),
    .hart_halted(hart_halted), .hart_halt_req(hart_halt_req),
    .hart_resume_req(hart_resume_req), .hart_resume_ack(hart_resume_ack),
    .dm_active(dm_active), .ndm_reset(ndm_reset),
    .cmd_req(cmd_req), .cmd_write(cmd_write), .cmd_regno(cmd_regno), .cmd_wdata(cmd_wdata),
    .cmd_ack(cmd_ack), .cmd_rdata(cmd_rdata), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%h expected=entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic sig(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    push(tag, exp);
    pop_cmp(obs);
  endtask

  // Called on a falling edge; returns on the next falling edge with the bus idle.
  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    dmi_req = 1'b1; dmi_wr = 1'b1; dmi_addr = a; dmi_wdata = d;
    @(negedge clk);
    dmi_req = 1'b0; dmi_wr = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
    push(tag, exp);
    push({tag, "_resp"}, 32'd1);
    dmi_req = 1'b1; dmi_wr = 1'b0; dmi_addr = a;
    #1;
    pop_cmp(dmi_rdata);
    pop_cmp({31'd0, dmi_resp});
    @(negedge clk);
    dmi_req = 1'b0;
  endtask

  task automatic ack(input logic [31:0] rdata, input logic err);
    cmd_ack = 1'b1; cmd_rdata = rdata; cmd_err = err;
    @(negedge clk);
    cmd_ack = 1'b0; cmd_err = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    // reset state
    push("rst_rdata", 32'd0);
    push("rst_resp", 32'd1);
    dmi_req = 1'b1; dmi_addr = 6'h11;
    #1;
    pop_cmp(dmi_rdata);
    pop_cmp({31'd0, dmi_resp});
    dmi_req = 1'b0;
    sig("rst_cmd_req", {31'd0, cmd_req}, 32'd0);
    sig("rst_halt_req", {31'd0, hart_halt_req}, 32'd0);
    sig("rst_dm_active", {31'd0, dm_active}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // activation and inactive-write suppression
    wr(6'h04, 32'hAAAA_5555);
    wr(6'h10, 32'h0000_0001);
    rd("data0_inactive", 6'h04, 32'd0);
    sig("dm_active", {31'd0, dm_active}, 32'd1);
    wr(6'h10, 32'h8000_0003);
    sig("halt_req", {31'd0, hart_halt_req}, 32'd1);
    sig("ndm_reset", {31'd0, ndm_reset}, 32'd1);
    rd("dmcontrol", 6'h10, 32'h8000_0003);
    rd("dmstatus_run", 6'h11, 32'h0000_0C82);
    rd("hartinfo", 6'h12, 32'd0);
    rd("abscs_idle", 6'h16, PBSZ | 32'h1);
    rd("command_reads0", 6'h17, 32'd0);
    wr(6'h10, 32'h0000_0001);

    // abstract write command
    hart_halted = 1'b1;
    @(negedge clk);
    rd("dmstatus_halt", 6'h11, 32'h0000_0382);
    wr(6'h04, 32'h1234_5678);
    wr(6'h17, 32'h0023_1001);
    sig("w_cmd_req", {31'd0, cmd_req}, 32'd1);
    sig("w_cmd_write", {31'd0, cmd_write}, 32'd1);
    sig("w_cmd_regno", {16'd0, cmd_regno}, 32'h1001);
    sig("w_cmd_wdata", cmd_wdata, 32'h1234_5678);
    rd("abscs_busy", 6'h16, PBSZ | 32'h1001);
    @(negedge clk);
    ack(32'hFFFF_FFFF, 1'b0);
    sig("w_done_req", {31'd0, cmd_req}, 32'd0);
    rd("abscs_after_w", 6'h16, PBSZ | 32'h1);
    rd("data0_after_w", 6'h04, 32'h1234_5678);

    // abstract read command
    wr(6'h17, 32'h0022_1002);
    sig("r_cmd_write", {31'd0, cmd_write}, 32'd0);
    sig("r_cmd_regno", {16'd0, cmd_regno}, 32'h1002);
    ack(32'hDEAD_BEEF, 1'b0);
    rd("data0_read", 6'h04, 32'hDEAD_BEEF);

    // busy violation, and completion racing a data0 write
    wr(6'h17, 32'h0022_1003);
    wr(6'h17, 32'h0023_1004);
    wr(6'h04, 32'h1111_1111);
    rd("abscs_busyerr", 6'h16, PBSZ | 32'h1101);
    sig("regno_held", {16'd0, cmd_regno}, 32'h1003);
    cmd_ack = 1'b1; cmd_rdata = 32'hCAFE_F00D;
    wr(6'h04, 32'h5555_5555);
    cmd_ack = 1'b0;
    rd("data0_race", 6'h04, 32'hCAFE_F00D);
    wr(6'h17, 32'h0023_1005);
    sig("cmd_blocked", {31'd0, cmd_req}, 32'd0);
    rd("abscs_err1", 6'h16, PBSZ | 32'h101);
    wr(6'h16, 32'h0000_0700);
    rd("abscs_clr", 6'h16, PBSZ | 32'h1);

    // halt / unsupported errors and per-bit clear
    hart_halted = 1'b0;
    wr(6'h17, 32'h0022_1000);
    sig("nohalt_req", {31'd0, cmd_req}, 32'd0);
    rd("abscs_err4", 6'h16, PBSZ | 32'h401);
    wr(6'h16, 32'h0000_0700);
    wr(6'h17, 32'h0102_0000);
    rd("abscs_err2", 6'h16, PBSZ | 32'h201);
    wr(6'h16, 32'h0000_0100);
    rd("abscs_w1c_other", 6'h16, PBSZ | 32'h201);
    wr(6'h16, 32'h0000_0200);
    rd("abscs_w1c", 6'h16, PBSZ | 32'h1);
    wr(6'h17, 32'h0031_0000);
    rd("abscs_aarsize", 6'h16, PBSZ | 32'h201);
    wr(6'h16, 32'h0000_0700);
    wr(6'h17, 32'h0020_0000);
    rd("abscs_notransfer", 6'h16, PBSZ | 32'h1);

    // exception on completion
    hart_halted = 1'b1;
    wr(6'h17, 32'h0022_1006);
    ack(32'h0BAD_0BAD, 1'b1);
    rd("abscs_err3", 6'h16, PBSZ | 32'h301);
    rd("data0_on_err", 6'h04, 32'hCAFE_F00D);
    wr(6'h16, 32'h0000_0700);

    // resume handshake
    wr(6'h10, 32'h4000_0001);
    sig("resume_req", {31'd0, hart_resume_req}, 32'd1);
    rd("dmstatus_noack", 6'h11, 32'h0000_0382);
    repeat (2) @(negedge clk);
    sig("resume_hold", {31'd0, hart_resume_req}, 32'd1);
    hart_resume_ack = 1'b1;
    @(negedge clk);
    hart_resume_ack = 1'b0;
    sig("resume_done", {31'd0, hart_resume_req}, 32'd0);
    rd("dmstatus_ack", 6'h11, 32'h0003_0382);
    rd("dmcontrol_noresume", 6'h10, 32'h0000_0001);

    // unmapped / optional progbuf
    wr(6'h3F, 32'hFFFF_FFFF);
    rd("unmapped", 6'h3F, 32'd0);
    wr(6'h20, 32'hA5A5_0001);
`ifdef SCR1_DMI_PROGBUF_EN
    rd("progbuf0", 6'h20, 32'hA5A5_0001);
`else
    rd("progbuf0_unmapped", 6'h20, 32'd0);
`endif

    // deactivation clears state
    wr(6'h04, 32'h0000_0077);
    wr(6'h10, 32'h0000_0000);
    rd("data0_deact", 6'h04, 32'd0);
    wr(6'h10, 32'h0000_0001);

    // reset during EXEC
    wr(6'h17, 32'h0022_1007);
    sig("exec_before_rst", {31'd0, cmd_req}, 32'd1);
    rst = 1'b1;
    #1;
    sig("rst_mid_exec", {31'd0, cmd_req}, 32'd0);
    sig("rst_regno", {16'd0, cmd_regno}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ack(32'h1357_9BDF, 1'b0);
    sig("late_ack_req", {31'd0, cmd_req}, 32'd0);
    rd("data0_late_ack", 6'h04, 32'd0);
    sig("dm_active_rst", {31'd0, dm_active}, 32'd0);

    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
